// File: rtl/set_arb.sv
// set_arb: two-requester round-robin front end for a single SET engine.
// Optional engine timeout is enabled with the SET_ARB_TIMEOUT_EN macro.
module set_arb #(
  parameter int unsigned TO_CYCLES = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_en,
  input  logic [23:0] req0_central,
  input  logic [11:0] req0_radius,
  input  logic [1:0]  req0_mode,
  output logic        req0_ready,
  input  logic        req1_en,
  input  logic [23:0] req1_central,
  input  logic [11:0] req1_radius,
  input  logic [1:0]  req1_mode,
  output logic        req1_ready,
  output logic        eng_en,
  output logic [23:0] eng_central,
  output logic [11:0] eng_radius,
  output logic [1:0]  eng_mode,
  input  logic        eng_busy,
  input  logic        eng_valid,
  input  logic [7:0]  eng_candidate,
  output logic        res_valid,
  output logic        res_id,
  output logic [7:0]  res_candidate,
  output logic        res_err
);

  localparam int unsigned CW = 24;
  localparam int unsigned RW = 12;
  localparam int unsigned MW = 2;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_pending;
  logic [CW-1:0] r_cen0, r_cen1;
  logic [RW-1:0] r_rad0, r_rad1;
  logic [MW-1:0] r_mode0, r_mode1;
  logic          r_gnt, r_last_gnt;

  logic w_acc0, w_acc1;
  logic w_grant, w_gnt_sel, w_launch, w_done, w_tmo;

`ifdef SET_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TO_CYCLES + 1);
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_res_err;
  assign res_err = r_res_err;
`else
  logic w_unused_to;
  assign w_unused_to = ^32'(TO_CYCLES);
  assign res_err     = 1'b0;
`endif

  assign req0_ready = ~r_pending[0];
  assign req1_ready = ~r_pending[1];
  assign w_acc0     = req0_en & ~r_pending[0];
  assign w_acc1     = req1_en & ~r_pending[1];

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_gnt_sel   = r_gnt;
    w_launch    = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_grant     = 1'b1;
          // With a single pending slot, bit 1 alone identifies it
          w_gnt_sel   = (&r_pending) ? ~r_last_gnt : r_pending[1];
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!eng_busy) begin
          w_launch    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_valid) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
`ifdef SET_ARB_TIMEOUT_EN
        else if (r_to_cnt == CNT_W'(TO_CYCLES - 1)) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Holding slots, grant bookkeeping, engine operands and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending     <= 2'b00;
      r_cen0        <= '0;
      r_cen1        <= '0;
      r_rad0        <= '0;
      r_rad1        <= '0;
      r_mode0       <= '0;
      r_mode1       <= '0;
      r_gnt         <= 1'b0;
      r_last_gnt    <= 1'b1;
      eng_en        <= 1'b0;
      eng_central   <= '0;
      eng_radius    <= '0;
      eng_mode      <= '0;
      res_valid     <= 1'b0;
      res_id        <= 1'b0;
      res_candidate <= '0;
    end else begin
      if (w_acc0) begin
        r_pending[0] <= 1'b1;
        r_cen0       <= req0_central;
        r_rad0       <= req0_radius;
        r_mode0      <= req0_mode;
      end else if ((w_done || w_tmo) && !r_gnt) begin
        r_pending[0] <= 1'b0;
      end

      if (w_acc1) begin
        r_pending[1] <= 1'b1;
        r_cen1       <= req1_central;
        r_rad1       <= req1_radius;
        r_mode1      <= req1_mode;
      end else if ((w_done || w_tmo) && r_gnt) begin
        r_pending[1] <= 1'b0;
      end

      if (w_grant) begin
        r_gnt       <= w_gnt_sel;
        r_last_gnt  <= w_gnt_sel;
        eng_central <= w_gnt_sel ? r_cen1  : r_cen0;
        eng_radius  <= w_gnt_sel ? r_rad1  : r_rad0;
        eng_mode    <= w_gnt_sel ? r_mode1 : r_mode0;
      end

      eng_en    <= w_launch;
      res_valid <= w_done | w_tmo;
      if (w_done) begin
        res_id        <= r_gnt;
        res_candidate <= eng_candidate;
      end else if (w_tmo) begin
        res_id        <= r_gnt;
        res_candidate <= '0;
      end
    end
  end

`ifdef SET_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_res_err <= 1'b0;
    end else begin
      if (w_launch)               r_to_cnt <= '0;
      else if (r_state == S_WAIT) r_to_cnt <= r_to_cnt + CNT_W'(1);
      if (w_done)     r_res_err <= 1'b0;
      else if (w_tmo) r_res_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_set_arb.sv
// Directed self-checking bench for set_arb; covers the timeout path when
// built with SET_ARB_TIMEOUT_EN.
module tb_set_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_en, req1_en;
  logic [23:0] req0_central, req1_central;
  logic [11:0] req0_radius, req1_radius;
  logic [1:0]  req0_mode, req1_mode;
  logic        req0_ready, req1_ready;
  logic        eng_en;
  logic [23:0] eng_central;
  logic [11:0] eng_radius;
  logic [1:0]  eng_mode;
  logic        eng_busy, eng_valid;
  logic [7:0]  eng_candidate;
  logic        res_valid, res_id, res_err;
  logic [7:0]  res_candidate;

  int n_total = 0;
  int n_bad   = 0;

  set_arb #(.TO_CYCLES(10)) dut (
    .clk(clk), .rst(rst),
    .req0_en(req0_en), .req0_central(req0_central), .req0_radius(req0_radius),
    .req0_mode(req0_mode), .req0_ready(req0_ready),
    .req1_en(req1_en), .req1_central(req1_central), .req1_radius(req1_radius),
    .req1_mode(req1_mode), .req1_ready(req1_ready),
    .eng_en(eng_en), .eng_central(eng_central), .eng_radius(eng_radius),
    .eng_mode(eng_mode), .eng_busy(eng_busy), .eng_valid(eng_valid),
    .eng_candidate(eng_candidate),
    .res_valid(res_valid), .res_id(res_id), .res_candidate(res_candidate),
    .res_err(res_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send0(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    req0_en = 1'b1; req0_central = c; req0_radius = r; req0_mode = m;
    tick();
    req0_en = 1'b0;
  endtask

  task automatic send1(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    req1_en = 1'b1; req1_central = c; req1_radius = r; req1_mode = m;
    tick();
    req1_en = 1'b0;
  endtask

  task automatic finish_result(input logic [7:0] cand);
    eng_valid = 1'b1; eng_candidate = cand;
    tick();
    eng_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0_en = 1'b0; req0_central = '0; req0_radius = '0; req0_mode = '0;
    req1_en = 1'b0; req1_central = '0; req1_radius = '0; req1_mode = '0;
    eng_busy = 1'b0; eng_valid = 1'b0; eng_candidate = '0;
    do_reset();

    // Reset state
    chk("rst_ready0", 32'(req0_ready), 32'd1);
    chk("rst_ready1", 32'(req1_ready), 32'd1);
    chk("rst_eng_en", 32'(eng_en), 32'd0);
    chk("rst_eng_central", 32'(eng_central), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_cand", 32'(res_candidate), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);

    // Single command, latency t+2
    send0(24'h440000, 12'h300, 2'd0);
    chk("t1_ready0_busy", 32'(req0_ready), 32'd0);
    chk("t1_en_t", 32'(eng_en), 32'd0);
    tick();
    chk("t1_en_t1", 32'(eng_en), 32'd0);
    tick();
    chk("t1_en_t2", 32'(eng_en), 32'd1);
    chk("t1_central", 32'(eng_central), 32'h440000);
    chk("t1_radius", 32'(eng_radius), 32'h300);
    tick();
    chk("t1_en_pulse", 32'(eng_en), 32'd0);
    finish_result(8'd29);
    chk("t1_res_valid", 32'(res_valid), 32'd1);
    chk("t1_res_id", 32'(res_id), 32'd0);
    chk("t1_res_cand", 32'(res_candidate), 32'd29);
    chk("t1_res_err", 32'(res_err), 32'd0);
    chk("t1_ready0_back", 32'(req0_ready), 32'd1);
    tick();
    chk("t1_res_pulse", 32'(res_valid), 32'd0);
    chk("t1_cand_hold", 32'(res_candidate), 32'd29);

    // Simultaneous requests after reset: req0 then req1
    do_reset();
    req0_en = 1'b1; req0_central = 24'h111111; req0_radius = 12'h111; req0_mode = 2'd1;
    req1_en = 1'b1; req1_central = 24'h222222; req1_radius = 12'h222; req1_mode = 2'd2;
    tick();
    req0_en = 1'b0; req1_en = 1'b0;
    tick();
    tick();
    chk("t2_en_a", 32'(eng_en), 32'd1);
    chk("t2_central_a", 32'(eng_central), 32'h111111);
    tick();
    finish_result(8'd5);
    chk("t2_res_id_a", 32'(res_id), 32'd0);
    chk("t2_res_cand_a", 32'(res_candidate), 32'd5);
    chk("t2_ready0_a", 32'(req0_ready), 32'd1);
    chk("t2_ready1_a", 32'(req1_ready), 32'd0);
    tick();
    tick();
    chk("t2_en_b", 32'(eng_en), 32'd1);
    chk("t2_central_b", 32'(eng_central), 32'h222222);
    chk("t2_mode_b", 32'(eng_mode), 32'd2);
    tick();
    finish_result(8'd7);
    chk("t2_res_valid_b", 32'(res_valid), 32'd1);
    chk("t2_res_id_b", 32'(res_id), 32'd1);
    chk("t2_res_cand_b", 32'(res_candidate), 32'd7);
    chk("t2_ready1_b", 32'(req1_ready), 32'd1);

    // Engine busy stalls the launch for 5 cycles
    tick();
    eng_busy = 1'b1;
    send0(24'hABCDEF, 12'h123, 2'd2);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_en_stall", 32'(eng_en), 32'd0);
      chk("t3_central_stall", 32'(eng_central), 32'hABCDEF);
    end
    eng_busy = 1'b0;
    tick();
    chk("t3_en_go", 32'(eng_en), 32'd1);
    tick();
    chk("t3_en_once", 32'(eng_en), 32'd0);
    chk("t3_central_wait", 32'(eng_central), 32'hABCDEF);
    chk("t3_radius_wait", 32'(eng_radius), 32'h123);
    chk("t3_mode_wait", 32'(eng_mode), 32'd2);
    finish_result(8'd3);
    chk("t3_res_cand", 32'(res_candidate), 32'd3);

    // Strobe on a pending slot is ignored
    tick();
    send1(24'h333333, 12'h333, 2'd3);
    req1_en = 1'b1; req1_central = 24'h999999; req1_radius = 12'h999; req1_mode = 2'd0;
    tick();
    tick();
    req1_en = 1'b0;
    chk("t4_central_orig", 32'(eng_central), 32'h333333);
    chk("t4_mode_orig", 32'(eng_mode), 32'd3);
    chk("t4_ready1_busy", 32'(req1_ready), 32'd0);
    tick();
    finish_result(8'h42);
    chk("t4_res_id", 32'(res_id), 32'd1);
    chk("t4_res_cand", 32'(res_candidate), 32'h42);
    tick();
    tick();
    chk("t4_no_relaunch", 32'(eng_en), 32'd0);
    chk("t4_ready1_idle", 32'(req1_ready), 32'd1);

    // Reset in WAIT discards the command
    send0(24'h010203, 12'h456, 2'd1);
    tick();
    tick();
    tick();
    do_reset();
    finish_result(8'h55);
    chk("t5_no_res", 32'(res_valid), 32'd0);
    chk("t5_ready0", 32'(req0_ready), 32'd1);
    chk("t5_ready1", 32'(req1_ready), 32'd1);
    tick();
    chk("t5_no_res_late", 32'(res_valid), 32'd0);
    chk("t5_cand_rst", 32'(res_candidate), 32'd0);

    // Engine never answers
    send0(24'h0F0F0F, 12'h0F0, 2'd0);
    tick();
    tick();
    chk("t6_en", 32'(eng_en), 32'd1);
`ifdef SET_ARB_TIMEOUT_EN
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t6_tmo_valid", 32'(res_valid), (k == 10) ? 32'd1 : 32'd0);
    end
    chk("t6_tmo_err", 32'(res_err), 32'd1);
    chk("t6_tmo_cand", 32'(res_candidate), 32'd0);
    chk("t6_tmo_id", 32'(res_id), 32'd0);
    tick();
    chk("t6_tmo_ready0", 32'(req0_ready), 32'd1);
    // Valid on the limit cycle wins over the timeout
    send0(24'h0A0A0A, 12'h0A0, 2'd1);
    tick();
    tick();
    for (int k = 1; k <= 9; k++) tick();
    finish_result(8'h77);
    chk("t6_prio_valid", 32'(res_valid), 32'd1);
    chk("t6_prio_err", 32'(res_err), 32'd0);
    chk("t6_prio_cand", 32'(res_candidate), 32'h77);
`else
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("t6_no_tmo", 32'(res_valid), 32'd0);
    end
    chk("t6_still_pending", 32'(req0_ready), 32'd0);
    chk("t6_err_tied", 32'(res_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/set_arb.md
SET_ARB -- requirements
Module: set_arb

Interface
REQ-001 The block SHALL have parameter TO_CYCLES, default 100, giving the engine-timeout limit in clk cycles (used only with SET_ARB_TIMEOUT_EN).
REQ-002 The block SHALL have these ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_en  input  1  requester 0 command strobe.
- req0_central  input  24  requester 0 circle centres A/B/C, 4-bit x/y nibbles.
- req0_radius  input  12  requester 0 radii A/B/C.
- req0_mode  input  2  requester 0 set-operation mode.
- req0_ready  output  1  requester 0 holding slot empty.
- req1_en / req1_central / req1_radius / req1_mode / req1_ready  same as requester 0, for requester 1.
- eng_en  output  1  one-cycle start pulse to SET engine.
- eng_central  output  24  engine operand.
- eng_radius  output  12  engine operand.
- eng_mode  output  2  engine operand.
- eng_busy  input  1  engine busy.
- eng_valid  input  1  engine result strobe.
- eng_candidate  input  8  engine point count.
- res_valid  output  1  one-cycle result pulse.
- res_id  output  1  requester that owns the result.
- res_candidate  output  8  returned count.
- res_err  output  1  result produced by timeout.

Function
REQ-003 Each requester SHALL own a one-deep holding slot (central, radius, mode, pending flag); reqN_ready SHALL equal ~pendingN, combinationally from the registered flag.
REQ-004 A command SHALL be accepted when reqN_en && reqN_ready at a rising edge; operands are captured and pendingN set at that edge. reqN_en while not ready SHALL be ignored with no state change.
REQ-005 The FSM SHALL have states IDLE, LAUNCH and WAIT.
REQ-006 In IDLE, if any slot is pending, the block SHALL grant one slot, latch its id as gnt, and move to LAUNCH on the next edge. If no slot is pending, it SHALL stay in IDLE.
REQ-007 Arbitration SHALL be round-robin: with both slots pending, grant the slot not equal to last_gnt; with one pending, grant it; last_gnt updates on each grant.
REQ-008 In LAUNCH, eng_en SHALL be 1 only while eng_busy==0, and the state SHALL then move to WAIT. While eng_busy==1, eng_en SHALL be 0 and the state SHALL stay LAUNCH.
REQ-009 eng_central, eng_radius and eng_mode SHALL be driven from the granted slot's registers and held stable through LAUNCH and WAIT. The engine samples them every cycle while busy.
REQ-010 In WAIT, on eng_valid, the block SHALL on the next cycle pulse res_valid=1 for exactly one cycle with res_id=gnt, res_candidate=eng_candidate and res_err=0. In the same edge it SHALL clear pending[gnt] and return to IDLE.
REQ-011 eng_valid outside WAIT SHALL be ignored.
REQ-012 res_id, res_candidate and res_err SHALL hold their last values between pulses.
REQ-013 Latency: from an accepting edge at cycle t into an idle block, eng_en SHALL be asserted in cycle t+2 if eng_busy==0.
REQ-014 When a slot clears, the requester SHALL see ready=1 in the following cycle. A new command into the other slot in the same cycle as a result SHALL be accepted normally.
REQ-015 A pending slot's operands SHALL never change until that slot's result is issued.

Reset
REQ-016 On rst=1 at a clock edge, the block SHALL set: state=IDLE, pending0/1=0, last_gnt=1 (requester 0 wins first tie), gnt=0, eng_en=0, eng_central=0, eng_radius=0, eng_mode=0, res_valid=0, res_id=0, res_candidate=0, res_err=0, timeout counter=0.
REQ-017 Reset mid-operation SHALL discard pending and in-flight commands with no result issued; req0_ready and req1_ready SHALL read 1 in the cycle after reset.

Configuration
REQ-018 With macro SET_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
- If it reaches TO_CYCLES without eng_valid, the block SHALL issue res_valid with res_id=gnt, res_candidate=0, res_err=1, clear pending[gnt] and return to IDLE.
- eng_valid in the same cycle the limit is reached SHALL take priority as a normal result.
REQ-019 Without SET_ARB_TIMEOUT_EN, no counter SHALL exist, res_err SHALL be tied 0, and WAIT SHALL wait indefinitely.

Verification
REQ-020 Single command: req0 central=24'h440000, radius=12'h300, mode=0 into the SET engine -> eng_en at t+2, then res_valid with res_id=0, res_candidate=8'd29, res_err=0.
REQ-021 Both requesters strobe in the same cycle after reset -> req0 served first, then req1; two res_valid pulses with res_id 0 then 1; ready for each returns 1 only after its own result.
REQ-022 eng_busy held 1 for 5 cycles on entering LAUNCH -> eng_en stays 0 for those 5 cycles, then pulses exactly once; operands are unchanged throughout.
REQ-023 req1_en pulsed while req1 is pending with different operands -> ignored; result carries the original command's count.
REQ-024 rst asserted mid-WAIT, then a late eng_valid -> no res_valid; both readies read 1.
REQ-025 With SET_ARB_TIMEOUT_EN and TO_CYCLES=10, engine never asserts valid -> res_valid 10 cycles after WAIT entry with res_err=1 and res_candidate=0; without the macro, no result is produced.
